// File: rtl/pulpemu_pkg.sv
// Shared types for the PULP emulation clock-gating controller.
// Holds the FSM state encoding and the per-state output decode.
package pulpemu_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_GATING = 3'd2,
        ST_GATED  = 3'd3,
        ST_WAKING = 3'd4
    } cg_state_e;

    typedef struct packed {
        logic clk_en;
        logic halt_req;
        logic ack;
    } cg_out_t;

    localparam int unsigned CNT_W = 8;

    function automatic cg_out_t cg_decode(input cg_state_e st);
        cg_out_t o;
        o = '{clk_en: 1'b1, halt_req: 1'b0, ack: 1'b0};
        case (st)
            ST_RUN:    o = '{clk_en: 1'b1, halt_req: 1'b0, ack: 1'b0};
            ST_DRAIN:  o = '{clk_en: 1'b1, halt_req: 1'b1, ack: 1'b0};
            ST_GATING: o = '{clk_en: 1'b0, halt_req: 1'b1, ack: 1'b0};
            ST_GATED:  o = '{clk_en: 1'b0, halt_req: 1'b1, ack: 1'b1};
            ST_WAKING: o = '{clk_en: 1'b1, halt_req: 1'b1, ack: 1'b0};
            default:   o = '{clk_en: 1'b1, halt_req: 1'b0, ack: 1'b0};
        endcase
        return o;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pulpemu_clk_gate_ctrl.sv
// Cluster clock-gating sequencer: drains the cluster, gates the clock,
// and restores it on wake or request release.
//
// state  | meaning
// RUN    | clock on, cluster free to run
// DRAIN  | halt requested, waiting for IDLE_CYCLES idle cycles
// GATING | clock enable dropped, waiting SETTLE_CYCLES
// GATED  | clock off and stable, ack asserted
// WAKING | clock enable restored, waiting SETTLE_CYCLES before RUN
module pulpemu_clk_gate_ctrl
    import pulpemu_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       pulp_cluster_clk,
    input  logic       pulp_soc_rst,
    input  logic       gate_req,
    input  logic       wake,
    input  logic       cluster_busy,
    output logic       pulp_cluster_clk_enable,
    output logic       cluster_halt_req,
    output logic       gate_ack,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    cg_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cg_out_t           out_q, out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                cnt_d = '0;
                if (gate_req && !wake) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Abort wins over the drain completing on the same cycle.
                if (!gate_req || wake) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cluster_busy) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LAST) begin
                    state_d = ST_GATING;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_GATING: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_GATED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_GATED: begin
                cnt_d = '0;
                if (!gate_req || wake) state_d = ST_WAKING;
            end
            ST_WAKING: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are flopped from the next-state decode so they always equal
    // the decode of state_q without any combinational path to the pins.
    always_comb begin
        out_d = cg_decode(state_d);
    end

    always_ff @(posedge pulp_cluster_clk or posedge pulp_soc_rst) begin
        if (pulp_soc_rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            out_q   <= cg_decode(ST_RUN);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign pulp_cluster_clk_enable = out_q.clk_en;
    assign cluster_halt_req        = out_q.halt_req;
    assign gate_ack                = out_q.ack;
    assign state                   = state_q;

endmodule

// File: tb/tb_pulpemu_clk_gate_ctrl.sv
// Self-checking bench for pulpemu_clk_gate_ctrl: a default-parameter
// instance driven from a vector table, plus a IDLE=1/SETTLE=1 instance.
module tb_pulpemu_clk_gate_ctrl;
    import pulpemu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       ga, wa, ba, en_a, hl_a, ak_a;
    logic [2:0] st_a;
    logic       gb, wb, bb, en_b, hl_b, ak_b;
    logic [2:0] st_b;

    pulpemu_clk_gate_ctrl #(.IDLE_CYCLES(4), .SETTLE_CYCLES(2)) u_dut_a (
        .pulp_cluster_clk        (clk),
        .pulp_soc_rst            (rst),
        .gate_req                (ga),
        .wake                    (wa),
        .cluster_busy            (ba),
        .pulp_cluster_clk_enable (en_a),
        .cluster_halt_req        (hl_a),
        .gate_ack                (ak_a),
        .state                   (st_a)
    );

    pulpemu_clk_gate_ctrl #(.IDLE_CYCLES(1), .SETTLE_CYCLES(1)) u_dut_b (
        .pulp_cluster_clk        (clk),
        .pulp_soc_rst            (rst),
        .gate_req                (gb),
        .wake                    (wb),
        .cluster_busy            (bb),
        .pulp_cluster_clk_enable (en_b),
        .cluster_halt_req        (hl_b),
        .gate_ack                (ak_b),
        .state                   (st_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       g;
        logic       w;
        logic       b;
        logic [2:0] st;
    } vec_t;

    typedef struct {
        string      name;
        int         dut;
        logic [2:0] st;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    // Expected {enable, halt_req, ack} per state, written out independently.
    function automatic logic [2:0] exp_outs(input logic [2:0] st);
        case (st)
            3'd0:    return 3'b100;
            3'd1:    return 3'b110;
            3'd2:    return 3'b010;
            3'd3:    return 3'b011;
            3'd4:    return 3'b110;
            default: return 3'b100;
        endcase
    endfunction

    task automatic check(input string name, input int dut, input logic [2:0] exp_st);
        logic [5:0] act, req;
        if (dut == 0) act = {st_a, en_a, hl_a, ak_a};
        else          act = {st_b, en_b, hl_b, ak_b};
        req = {exp_st, exp_outs(exp_st)};
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d: got state=%0d en/halt/ack=%b, expected state=%0d en/halt/ack=%b",
                     name, dut, act[5:3], act[2:0], req[5:3], req[2:0]);
        end
    endtask

    task automatic add(input logic g, input logic w, input logic b, input logic [2:0] st);
        vec_t v;
        v.g = g; v.w = w; v.b = b; v.st = st;
        tbl.push_back(v);
    endtask

    // Drive at the falling edge, push expectation, compare 1 ns after the rise.
    task automatic step(input string name, input int dut,
                        input logic g, input logic w, input logic b,
                        input logic [2:0] st);
        exp_t e;
        @(negedge clk);
        if (dut == 0) begin ga = g; wa = w; ba = b; end
        else          begin gb = g; wb = w; bb = b; end
        e.name = name; e.dut = dut; e.st = st;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty %s", name);
        end else begin
            e = sb.pop_front();
            check(e.name, e.dut, e.st);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ga = 0; wa = 0; ba = 0;
        gb = 0; wb = 0; bb = 0;

        // nominal gate, release
        repeat (4) add(1, 0, 0, ST_DRAIN);
        add(1, 0, 0, ST_GATING); add(1, 0, 0, ST_GATING);
        add(1, 0, 0, ST_GATED);  add(1, 0, 0, ST_GATED);
        add(0, 0, 0, ST_WAKING); add(0, 0, 0, ST_WAKING);
        add(0, 0, 0, ST_RUN);    add(0, 0, 1, ST_RUN);
        // busy restart, busy ignored in GATING
        repeat (3) add(1, 0, 0, ST_DRAIN);
        add(1, 0, 1, ST_DRAIN);
        repeat (3) add(1, 0, 0, ST_DRAIN);
        add(1, 0, 0, ST_GATING); add(1, 0, 1, ST_GATING); add(1, 0, 1, ST_GATED);
        // wake with gate_req held
        add(1, 1, 0, ST_WAKING); add(1, 1, 0, ST_WAKING);
        add(1, 1, 0, ST_RUN); add(1, 1, 0, ST_RUN); add(1, 1, 0, ST_RUN);
        add(1, 0, 0, ST_DRAIN); add(1, 0, 0, ST_DRAIN);
        // abort via gate_req drop at edge 2
        add(0, 0, 0, ST_RUN); add(0, 0, 0, ST_RUN);
        // abort via wake
        add(1, 0, 0, ST_DRAIN); add(1, 1, 0, ST_RUN); add(1, 1, 0, ST_RUN); add(0, 0, 0, ST_RUN);
        // abort beats drain completion
        repeat (4) add(1, 0, 0, ST_DRAIN);
        add(0, 0, 0, ST_RUN); add(0, 0, 0, ST_RUN);
        // GATING ignores inputs, WAKING ignores inputs, regate after RUN
        repeat (4) add(1, 0, 0, ST_DRAIN);
        add(1, 0, 0, ST_GATING); add(0, 1, 0, ST_GATING); add(0, 1, 0, ST_GATED);
        add(0, 0, 0, ST_WAKING); add(1, 0, 0, ST_WAKING); add(1, 0, 0, ST_RUN);
        add(1, 0, 0, ST_DRAIN); add(0, 0, 0, ST_RUN);

        repeat (2) @(negedge clk);
        check("reset_state_a", 0, ST_RUN);
        check("reset_state_b", 1, ST_RUN);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("tbl[%0d]", i), 0, tbl[i].g, tbl[i].w, tbl[i].b, tbl[i].st);

        // asynchronous reset while GATED
        repeat (4) step("to_gated_drain", 0, 1, 0, 0, ST_DRAIN);
        repeat (2) step("to_gated_gating", 0, 1, 0, 0, ST_GATING);
        step("to_gated", 0, 1, 0, 0, ST_GATED);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_in_gated", 0, ST_RUN);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("gate_req_at_reset_release", 0, ST_DRAIN);
        step("post_reset_release", 0, 0, 0, 0, ST_RUN);

        // IDLE=1, SETTLE=1 corner
        step("corner_drain",  1, 1, 0, 0, ST_DRAIN);
        step("corner_gating", 1, 1, 0, 0, ST_GATING);
        step("corner_gated",  1, 1, 0, 0, ST_GATED);
        step("corner_waking", 1, 0, 0, 0, ST_WAKING);
        step("corner_run",    1, 0, 0, 0, ST_RUN);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: %0d entries, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
